// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - execute-stage hazard detection and operand bypass control
//
// Decodes the instruction held in IF/ID. It keeps shadow copies of the destination
// information for the ID/EX (EX slot) and EX/MEM (MEM slot) instructions. From these
// it produces registered bypass selects and a combinational load-use stall.
//
// Ports:
//   clk                  - clock, rising edge
//   rst_n                - asynchronous active-low reset
//   ifid_ir[31:0]        - instruction currently in ID
//   flush                - squash the ID instruction (bubble into ID/EX)
//   stall                - combinational load-use stall to the front end
//   bypassA*/bypassB*    - registered operand selects for the ID/EX instruction
//   stall_cnt[CNT_W-1:0] - saturating count of stall cycles since reset
module ex_hazard_ctrl #(
    parameter logic [5:0] LW_OP      = 6'd35,
    parameter logic [5:0] SW_OP      = 6'd43,
    parameter logic [5:0] ALU_OP     = 6'd0,
    parameter logic [5:0] CINDC_OP   = 6'd47,
    parameter logic [5:0] BEQINIT_OP = 6'd4,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ifid_ir,
    input  logic             flush,
    output logic             stall,
    output logic             bypassAfromMEM,
    output logic             bypassAfromALUinWB,
    output logic             bypassAfromLWinWB,
    output logic             bypassBfromMEM,
    output logic             bypassBfromALUinWB,
    output logic             bypassBfromLWinWB,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [5:0] op;
    logic [4:0] rs, rt, rd;

    assign op = ifid_ir[31:26];
    assign rs = ifid_ir[25:21];
    assign rt = ifid_ir[20:16];
    assign rd = ifid_ir[15:11];

    // Decoded view of the ID instruction
    logic       uses_rs, uses_rt;
    logic [4:0] id_dst;
    logic       id_wr, id_ld;

    // Shadow slots
    logic [4:0] ex_dst, mem_dst;
    logic       ex_wr, ex_ld, mem_wr, mem_ld;

    // Next-state bypass selects
    logic a_mem, a_alu_wb, a_lw_wb;
    logic b_mem, b_alu_wb, b_lw_wb;
    logic bubble;

    always_comb begin
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        id_dst  = 5'd0;
        id_ld   = 1'b0;
        if (op == ALU_OP || op == CINDC_OP) begin
            uses_rs = 1'b1;
            uses_rt = 1'b1;
            id_dst  = rd;
        end else if (op == LW_OP) begin
            uses_rs = 1'b1;
            id_dst  = rt;
            id_ld   = 1'b1;
        end else if (op == SW_OP) begin
            uses_rs = 1'b1;
            uses_rt = 1'b1;
        end
        // BEQINIT_OP and unknown opcodes fall through: no reads, no write.
        // Writing r0 has no architectural effect, so it never produces a bypass.
        id_wr = (id_dst != 5'd0);
    end

    // A load still in EX cannot forward yet; the dependent instruction must wait a cycle.
    assign stall = !flush && ex_ld && ex_wr &&
                   ((uses_rs && rs == ex_dst) || (uses_rt && rt == ex_dst));

    assign bubble = stall || flush;

    // The EX-slot producer is younger than the MEM-slot one, so it masks the WB paths.
    always_comb begin
        a_mem    = uses_rs && ex_wr && !ex_ld && (rs == ex_dst);
        a_alu_wb = uses_rs && !a_mem && mem_wr && !mem_ld && (rs == mem_dst);
        a_lw_wb  = uses_rs && !a_mem && mem_wr &&  mem_ld && (rs == mem_dst);
        b_mem    = uses_rt && ex_wr && !ex_ld && (rt == ex_dst);
        b_alu_wb = uses_rt && !b_mem && mem_wr && !mem_ld && (rt == mem_dst);
        b_lw_wb  = uses_rt && !b_mem && mem_wr &&  mem_ld && (rt == mem_dst);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_dst             <= 5'd0;
            ex_wr              <= 1'b0;
            ex_ld              <= 1'b0;
            mem_dst            <= 5'd0;
            mem_wr             <= 1'b0;
            mem_ld             <= 1'b0;
            bypassAfromMEM     <= 1'b0;
            bypassAfromALUinWB <= 1'b0;
            bypassAfromLWinWB  <= 1'b0;
            bypassBfromMEM     <= 1'b0;
            bypassBfromALUinWB <= 1'b0;
            bypassBfromLWinWB  <= 1'b0;
            stall_cnt          <= '0;
        end else begin
            mem_dst <= ex_dst;
            mem_wr  <= ex_wr;
            mem_ld  <= ex_ld;
            if (bubble) begin
                ex_dst             <= 5'd0;
                ex_wr              <= 1'b0;
                ex_ld              <= 1'b0;
                bypassAfromMEM     <= 1'b0;
                bypassAfromALUinWB <= 1'b0;
                bypassAfromLWinWB  <= 1'b0;
                bypassBfromMEM     <= 1'b0;
                bypassBfromALUinWB <= 1'b0;
                bypassBfromLWinWB  <= 1'b0;
            end else begin
                ex_dst             <= id_dst;
                ex_wr              <= id_wr;
                ex_ld              <= id_ld;
                bypassAfromMEM     <= a_mem;
                bypassAfromALUinWB <= a_alu_wb;
                bypassAfromLWinWB  <= a_lw_wb;
                bypassBfromMEM     <= b_mem;
                bypassBfromALUinWB <= b_alu_wb;
                bypassBfromLWinWB  <= b_lw_wb;
            end
            if (stall && stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb/tb_ex_hazard_ctrl.sv - directed self-checking bench for ex_hazard_ctrl
module tb_ex_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] ifid_ir;
    logic        flush;
    logic        stall;
    logic        amem, aalu, alw, bmem, balu, blw;
    logic [15:0] stall_cnt;
    logic [5:0]  sel;

    int checks = 0;
    int errors = 0;

    ex_hazard_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ifid_ir            (ifid_ir),
        .flush              (flush),
        .stall              (stall),
        .bypassAfromMEM     (amem),
        .bypassAfromALUinWB (aalu),
        .bypassAfromLWinWB  (alw),
        .bypassBfromMEM     (bmem),
        .bypassBfromALUinWB (balu),
        .bypassBfromLWinWB  (blw),
        .stall_cnt          (stall_cnt)
    );

    // {A mem, A alu-wb, A lw-wb, B mem, B alu-wb, B lw-wb}
    assign sel = {amem, aalu, alw, bmem, balu, blw};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input int s, input int t, input int d, input int fn);
        return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int o, input int s, input int t, input int imm);
        return {6'(o), 5'(s), 5'(t), 16'(imm)};
    endfunction

    // Present an instruction for one cycle; outputs are sampled mid-cycle.
    task automatic cyc(input logic [31:0] ir, input logic f);
        @(negedge clk);
        ifid_ir = ir;
        flush   = f;
        #1;
    endtask

    task automatic drain();
        cyc(32'd0, 1'b0);
        cyc(32'd0, 1'b0);
        cyc(32'd0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        ifid_ir = 32'd0;
        flush   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        checks++;
        if (sel !== 6'b000000) begin errors++; $display("FAIL reset_sel got %b want 000000", sel); end
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        drain();
        cyc(32'h00221820, 1'b0);
        cyc(32'h00612020, 1'b0);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b want 0", stall); end
        cyc(32'd0, 1'b0);
        checks++;
        if (sel !== 6'b100000) begin errors++; $display("FAIL b2b_sel got %b want 100000", sel); end
    endtask

    task automatic test_gap_one();
        drain();
        cyc(rtype(1, 2, 3, 32), 1'b0);
        cyc(rtype(6, 7, 5, 32), 1'b0);
        cyc(rtype(1, 3, 8, 50), 1'b0);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL gap_stall got %b want 0", stall); end
        cyc(32'd0, 1'b0);
        checks++;
        if (sel !== 6'b000010) begin errors++; $display("FAIL gap_sel got %b want 000010", sel); end
    endtask

    task automatic test_load_use();
        drain();
        cyc(itype(35, 1, 2, 0), 1'b0);
        cyc(rtype(2, 2, 4, 32), 1'b0);
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", stall); end
        cyc(rtype(2, 2, 4, 32), 1'b0);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_drop got %b want 0", stall); end
        checks++;
        if (sel !== 6'b000000) begin errors++; $display("FAIL lu_bubble_sel got %b want 000000", sel); end
        checks++;
        if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", stall_cnt); end
        cyc(32'd0, 1'b0);
        checks++;
        if (sel !== 6'b001001) begin errors++; $display("FAIL lu_sel got %b want 001001", sel); end
    endtask

    task automatic test_double_producer();
        drain();
        cyc(rtype(1, 2, 3, 32), 1'b0);
        cyc(rtype(1, 2, 3, 32), 1'b0);
        cyc(itype(43, 3, 3, 4), 1'b0);
        cyc(32'd0, 1'b0);
        checks++;
        if (sel !== 6'b100100) begin errors++; $display("FAIL dbl_sel got %b want 100100", sel); end
    endtask

    task automatic test_r0_beqinit();
        drain();
        cyc(rtype(1, 2, 0, 32), 1'b0);
        cyc(rtype(0, 0, 4, 32), 1'b0);
        cyc(32'd0, 1'b0);
        checks++;
        if (sel !== 6'b000000) begin errors++; $display("FAIL r0_sel got %b want 000000", sel); end
        drain();
        cyc(itype(35, 1, 5, 0), 1'b0);
        cyc(itype(4, 5, 5, 8), 1'b0);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL beq_stall got %b want 0", stall); end
        cyc(32'd0, 1'b0);
        checks++;
        if (sel !== 6'b000000) begin errors++; $display("FAIL beq_sel got %b want 000000", sel); end
    endtask

    task automatic test_flush();
        drain();
        cyc(itype(35, 1, 2, 0), 1'b0);
        cyc(rtype(2, 2, 4, 32), 1'b1);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall); end
        cyc(rtype(4, 4, 5, 32), 1'b0);
        checks++;
        if (stall_cnt !== 16'd1) begin errors++; $display("FAIL flush_cnt got %0d want 1", stall_cnt); end
        checks++;
        if (sel !== 6'b000000) begin errors++; $display("FAIL flush_bubble_sel got %b want 000000", sel); end
        cyc(32'd0, 1'b0);
        checks++;
        if (sel !== 6'b000000) begin errors++; $display("FAIL flush_squashed_sel got %b want 000000", sel); end
    endtask

    task automatic test_reset_mid_stall();
        drain();
        cyc(rtype(2, 3, 1, 32), 1'b0);
        cyc(itype(35, 1, 2, 0), 1'b0);
        cyc(rtype(2, 2, 4, 32), 1'b0);
        checks++;
        if (stall !== 1'b1 || sel !== 6'b100000 || stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL pre_reset got stall=%b sel=%b cnt=%0d want stall=1 sel=100000 cnt=1",
                     stall, sel, stall_cnt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall got %b want 0", stall); end
        checks++;
        if (sel !== 6'b000000) begin errors++; $display("FAIL midrst_sel got %b want 000000", sel); end
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL midrst_cnt got %0d want 0", stall_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(rtype(2, 2, 4, 32), 1'b0);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL postrst_stall got %b want 0", stall); end
        cyc(32'd0, 1'b0);
        checks++;
        if (sel !== 6'b000000 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL postrst got sel=%b cnt=%0d want sel=000000 cnt=0", sel, stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gap_one();
        test_load_use();
        test_double_producer();
        test_r0_beqinit();
        test_flush();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
